calendar: RTL

Date-keeping stage directly downstream of the time-of-day counter. It consumes that counter's `end_of_day` flag and the shared 1 Hz tick, and maintains day, month and year with full Gregorian leap-year rules. It also applies the user set buttons for day, month and year, and exports an `end_of_year` flag for any later stage. It runs on the system clock, with `tick_1Hz` acting as a one-cycle enable.

---
 rtl/calendar_pkg.sv | 44 ++++
 rtl/calendar_month_length.sv | 10 +
 rtl/calendar.sv | 80 ++++++++
 3 files changed

// File: rtl/calendar_pkg.sv
// Shared widths, month constants and Gregorian month-length helpers for the
// calendar stage.
package calendar_pkg;
  localparam int DAY_W   = 8;
  localparam int MONTH_W = 8;
  localparam int YEAR_W  = 16;

  localparam logic [MONTH_W-1:0] JAN = 8'd1;
  localparam logic [MONTH_W-1:0] FEB = 8'd2;
  localparam logic [MONTH_W-1:0] MAR = 8'd3;
  localparam logic [MONTH_W-1:0] APR = 8'd4;
  localparam logic [MONTH_W-1:0] MAY = 8'd5;
  localparam logic [MONTH_W-1:0] JUN = 8'd6;
  localparam logic [MONTH_W-1:0] JUL = 8'd7;
  localparam logic [MONTH_W-1:0] AUG = 8'd8;
  localparam logic [MONTH_W-1:0] SEP = 8'd9;
  localparam logic [MONTH_W-1:0] OCT = 8'd10;
  localparam logic [MONTH_W-1:0] NOV = 8'd11;
  localparam logic [MONTH_W-1:0] DEC = 8'd12;

  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
  } date_t;

  // 400 = 16*25, so once divisible by 100 a 16-divisibility check is enough.
  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    logic div4, div16, div100;
    div4   = (year[1:0] == 2'b00);
    div16  = (year[3:0] == 4'h0);
    div100 = ((year % 16'd100) == 16'd0);
    return div4 && (!div100 || div16);
  endfunction

  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic leap);
    case (month)
      FEB:                days_in_month = leap ? 8'd29 : 8'd28;
      APR, JUN, SEP, NOV: days_in_month = 8'd30;
      default:            days_in_month = 8'd31;
    endcase
  endfunction
endpackage

// File: rtl/calendar_month_length.sv
// Days in a given month of a given year (combinational).
module month_length
  import calendar_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   dim
);
  assign dim = days_in_month(month, is_leap(year));
endmodule

// File: rtl/calendar.sv
// Day/month/year keeper: end-of-day rollover plus set buttons, one action per
// 1 Hz tick, with day clamping when month or year changes under it.
module calendar
  import calendar_pkg::*;
#(
  parameter int DEFAULT_DAY   = 1,
  parameter int DEFAULT_MONTH = 1,
  parameter int DEFAULT_YEAR  = 2000,
  parameter int MIN_YEAR      = 2000,
  parameter int MAX_YEAR      = 2099
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_1Hz,
  input  logic         end_of_day,
  input  logic         inc_day,
  input  logic         inc_month,
  input  logic         inc_year,
  output logic [7:0]   day,
  output logic [7:0]   month,
  output logic [15:0]  year,
  output logic         end_of_year
);
  localparam logic [YEAR_W-1:0]  MIN_Y = YEAR_W'(MIN_YEAR);
  localparam logic [YEAR_W-1:0]  MAX_Y = YEAR_W'(MAX_YEAR);
  localparam date_t RST_DATE = '{year:  YEAR_W'(DEFAULT_YEAR),
                                 month: MONTH_W'(DEFAULT_MONTH),
                                 day:   DAY_W'(DEFAULT_DAY)};

  date_t              date_q, date_d;
  logic [YEAR_W-1:0]  year_inc, clamp_year;
  logic [MONTH_W-1:0] month_inc, clamp_month;
  logic [DAY_W-1:0]   dim, clamp_dim, clamp_day;

  assign year_inc  = (date_q.year >= MAX_Y) ? MIN_Y : date_q.year + 16'd1;
  assign month_inc = (date_q.month >= DEC) ? JAN : date_q.month + 8'd1;

  // Second length lookup sees the date the set button is about to produce.
  assign clamp_year  = inc_year ? year_inc : date_q.year;
  assign clamp_month = inc_year ? date_q.month : month_inc;
  assign clamp_day   = (date_q.day > clamp_dim) ? clamp_dim : date_q.day;

  month_length u_cur_len (.month(date_q.month), .year(date_q.year), .dim(dim));
  month_length u_nxt_len (.month(clamp_month), .year(clamp_year), .dim(clamp_dim));

  always_comb begin
    date_d = date_q;
    if (end_of_day) begin
      if (date_q.day < dim) begin
        date_d.day = date_q.day + 8'd1;
      end else begin
        date_d.day = 8'd1;
        if (date_q.month >= DEC) begin
          date_d.month = JAN;
          date_d.year  = year_inc;
        end else begin
          date_d.month = date_q.month + 8'd1;
        end
      end
    end else if (inc_year) begin
      date_d.year = year_inc;
      date_d.day  = clamp_day;
    end else if (inc_month) begin
      date_d.month = month_inc;
      date_d.day   = clamp_day;
    end else if (inc_day) begin
      date_d.day = (date_q.day >= dim) ? 8'd1 : date_q.day + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         date_q <= RST_DATE;
    else if (tick_1Hz) date_q <= date_d;
  end

  assign day         = date_q.day;
  assign month       = date_q.month;
  assign year        = date_q.year;
  assign end_of_year = end_of_day && (date_q.month == DEC) && (date_q.day == 8'd31);
endmodule
